// File: rtl/fp_pkg.sv
// Shared types and constants for the single-precision add/sub pipeline.
// Stage payloads carry either an aligned magnitude pair/sum or a precomputed special result.
package fp_pkg;

  localparam int WIDTH     = 32;
  localparam int EXP_BITS  = 8;
  localparam int MANT_BITS = 23;
  localparam int BIAS      = 127;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;
  localparam logic [31:0] NEG_INF = 32'hFF80_0000;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [22:0] mant;
  } fp32_t;

  // x_mag/y_mag: 24-bit significand followed by guard, round, sticky
  typedef struct packed {
    logic        special;
    logic [31:0] special_val;
    logic        invalid;
    logic        sign;
    logic [7:0]  exp;
    logic        eff_sub;
    logic [26:0] x_mag;
    logic [26:0] y_mag;
  } s1_t;

  typedef struct packed {
    logic        special;
    logic [31:0] special_val;
    logic        invalid;
    logic        sign;
    logic [7:0]  exp;
    logic [27:0] sum;
  } s2_t;

  function automatic logic is_nan(fp32_t f);
    return (f.exp == 8'hFF) && (f.mant != '0);
  endfunction

  function automatic logic is_inf(fp32_t f);
    return (f.exp == 8'hFF) && (f.mant == '0);
  endfunction

endpackage

// File: rtl/fp_add_sub_pipe_if.sv
// Input/output handshake bundle of the add/sub pipeline.
// The slave modport is the core's view, master is the producer/consumer side.
interface fp_add_sub_pipe_if;
  import fp_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 operation_select;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     result;
  logic                 sign_result;
  logic [EXP_BITS-1:0]  exp_result;
  logic [MANT_BITS-1:0] mantissa_result;
  logic                 flag_invalid;
  logic                 flag_overflow;
  logic                 flag_inexact;

  modport master (
    output in_valid, a, b, operation_select, out_ready,
    input  in_ready, out_valid, result, sign_result, exp_result, mantissa_result,
           flag_invalid, flag_overflow, flag_inexact
  );

  modport slave (
    input  in_valid, a, b, operation_select, out_ready,
    output in_ready, out_valid, result, sign_result, exp_result, mantissa_result,
           flag_invalid, flag_overflow, flag_inexact
  );

endinterface

// File: rtl/fp_lzc28.sv
// Combinational leading-zero count of a 28-bit vector; all-zero input gives 28.
module fp_lzc28 (
  input  logic [27:0] din,
  output logic [4:0]  cnt
);

  always_comb begin
    cnt = 5'd28;
    for (int i = 0; i < 28; i++) begin
      if (din[i]) cnt = 5'(27 - i);
    end
  end

endmodule

// File: rtl/fp_add_sub_pipe.sv
// Three-stage IEEE-754 single-precision add/subtract (FTZ, round-to-nearest-even).
// S1 unpack/align, S2 magnitude add, S3 normalize/round/pack; one shared advance enable.
module fp_add_sub_pipe
  import fp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  fp_add_sub_pipe_if.slave io
);

  logic adv;

  logic v1_q, v1_d, v2_q, v2_d, out_valid_q, out_valid_d;
  s1_t  s1_q, s1_d, s1_c;
  s2_t  s2_q, s2_d, s2_c;
  logic [31:0] result_q, result_d, result_c;
  logic flag_invalid_q, flag_invalid_d, flag_invalid_c;
  logic flag_overflow_q, flag_overflow_d, flag_overflow_c;
  logic flag_inexact_q, flag_inexact_d, flag_inexact_c;

  fp32_t       fa, fb;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, swap, x_sign;
  logic [30:0] ka, kb, kx, ky;
  logic [23:0] x_sig, y_sig;
  logic [7:0]  d;
  logic [26:0] y_full;

  assign adv = !out_valid_q | io.out_ready;

  always_comb begin
    fa      = fp32_t'(io.a);
    fb      = fp32_t'(io.b);
    fb.sign = io.b[31] ^ io.operation_select;
    a_nan   = is_nan(fa);
    b_nan   = is_nan(fb);
    a_inf   = is_inf(fa);
    b_inf   = is_inf(fb);
    a_zero  = (fa.exp == 8'd0);
    b_zero  = (fb.exp == 8'd0);
    // denormals collapse to zero before the magnitude compare
    ka      = a_zero ? 31'd0 : {fa.exp, fa.mant};
    kb      = b_zero ? 31'd0 : {fb.exp, fb.mant};
    swap    = (kb > ka);
    kx      = swap ? kb : ka;
    ky      = swap ? ka : kb;
    x_sign  = swap ? fb.sign : fa.sign;
    x_sig   = (kx[30:23] != 8'd0) ? {1'b1, kx[22:0]} : 24'd0;
    y_sig   = (ky[30:23] != 8'd0) ? {1'b1, ky[22:0]} : 24'd0;
    d       = kx[30:23] - ky[30:23];
    y_full  = {y_sig, 3'b000};

    s1_c         = '0;
    s1_c.sign    = x_sign;
    s1_c.exp     = kx[30:23];
    s1_c.eff_sub = fa.sign ^ fb.sign;
    s1_c.x_mag   = {x_sig, 3'b000};
    if (d >= 8'd27) s1_c.y_mag = {26'd0, |y_sig};
    else s1_c.y_mag = (y_full >> d) | {26'd0, |(y_full & ~(27'h7FF_FFFF << d))};

    if (a_nan || b_nan || (a_inf && b_inf && (fa.sign != fb.sign))) begin
      s1_c.special     = 1'b1;
      s1_c.special_val = QNAN;
      s1_c.invalid     = 1'b1;
    end else if (a_inf) begin
      s1_c.special     = 1'b1;
      s1_c.special_val = fa.sign ? NEG_INF : POS_INF;
    end else if (b_inf) begin
      s1_c.special     = 1'b1;
      s1_c.special_val = fb.sign ? NEG_INF : POS_INF;
    end else if (a_zero && b_zero) begin
      s1_c.special     = 1'b1;
      s1_c.special_val = {fa.sign & fb.sign, 31'd0};
    end
  end

  always_comb begin
    s2_c.special     = s1_q.special;
    s2_c.special_val = s1_q.special_val;
    s2_c.invalid     = s1_q.invalid;
    s2_c.sign        = s1_q.sign;
    s2_c.exp         = s1_q.exp;
    // x >= y by construction, so the difference never goes negative
    s2_c.sum = s1_q.eff_sub ? ({1'b0, s1_q.x_mag} - {1'b0, s1_q.y_mag})
                            : ({1'b0, s1_q.x_mag} + {1'b0, s1_q.y_mag});
  end

  logic [4:0]         lzc;
  logic [27:0]        norm;
  logic               g, rest, round_up;
  logic [24:0]        sig25;
  logic signed [9:0]  e;

  fp_lzc28 u_lzc (
    .din (s2_q.sum),
    .cnt (lzc)
  );

  always_comb begin
    norm     = s2_q.sum << lzc;
    g        = norm[3];
    rest     = |norm[2:0];
    round_up = g & (rest | norm[4]);
    sig25    = {1'b0, norm[27:4]} + {24'd0, round_up};
    // bit 27 of the sum sits one binade above the operand exponent
    e = $signed({2'b00, s2_q.exp}) + 10'sd1 - $signed({5'd0, lzc}) + $signed({9'd0, sig25[24]});

    result_c        = '0;
    flag_invalid_c  = 1'b0;
    flag_overflow_c = 1'b0;
    flag_inexact_c  = 1'b0;
    if (s2_q.special) begin
      result_c       = s2_q.special_val;
      flag_invalid_c = s2_q.invalid;
    end else if (s2_q.sum == '0) begin
      result_c = '0;
    end else if (e >= 10'sd255) begin
      result_c        = s2_q.sign ? NEG_INF : POS_INF;
      flag_overflow_c = 1'b1;
      flag_inexact_c  = g | rest;
    end else if (e <= 10'sd0) begin
      result_c       = {s2_q.sign, 31'd0};
      flag_inexact_c = g | rest;
    end else begin
      result_c       = {s2_q.sign, e[7:0], sig25[24] ? sig25[23:1] : sig25[22:0]};
      flag_inexact_c = g | rest;
    end
  end

  always_comb begin
    v1_d            = v1_q;
    v2_d            = v2_q;
    out_valid_d     = out_valid_q;
    s1_d            = s1_q;
    s2_d            = s2_q;
    result_d        = result_q;
    flag_invalid_d  = flag_invalid_q;
    flag_overflow_d = flag_overflow_q;
    flag_inexact_d  = flag_inexact_q;
    if (adv) begin
      v1_d            = io.in_valid;
      v2_d            = v1_q;
      out_valid_d     = v2_q;
      s1_d            = s1_c;
      s2_d            = s2_c;
      result_d        = result_c;
      flag_invalid_d  = flag_invalid_c;
      flag_overflow_d = flag_overflow_c;
      flag_inexact_d  = flag_inexact_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q            <= 1'b0;
      v2_q            <= 1'b0;
      out_valid_q     <= 1'b0;
      s1_q            <= '0;
      s2_q            <= '0;
      result_q        <= '0;
      flag_invalid_q  <= 1'b0;
      flag_overflow_q <= 1'b0;
      flag_inexact_q  <= 1'b0;
    end else begin
      v1_q            <= v1_d;
      v2_q            <= v2_d;
      out_valid_q     <= out_valid_d;
      s1_q            <= s1_d;
      s2_q            <= s2_d;
      result_q        <= result_d;
      flag_invalid_q  <= flag_invalid_d;
      flag_overflow_q <= flag_overflow_d;
      flag_inexact_q  <= flag_inexact_d;
    end
  end

  assign io.in_ready        = adv;
  assign io.out_valid       = out_valid_q;
  assign io.result          = result_q;
  assign io.sign_result     = result_q[31];
  assign io.exp_result      = result_q[30:23];
  assign io.mantissa_result = result_q[22:0];
  assign io.flag_invalid    = flag_invalid_q;
  assign io.flag_overflow   = flag_overflow_q;
  assign io.flag_inexact    = flag_inexact_q;

endmodule

// File: tb/tb_fp_add_sub_pipe.sv
// Bench for fp_add_sub_pipe: directed corner cases, stall/reset streams and random ops
// scored against an exact wide-integer reference model.
module tb_fp_add_sub_pipe;
  import fp_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_add_sub_pipe_if bus ();

  fp_add_sub_pipe dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int out_cnt = 0;
  logic [34:0] exp_q[$];
  int          acc_q[$];
  bit          lat_chk = 1'b0;
  bit          was_stalled = 1'b0;
  logic [34:0] held;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Exact model: operands become integers in units of 2^-149, summed exactly, then rounded.
  function automatic logic [34:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic op);
    logic        sa, sb, ss, up, inexact;
    logic [7:0]  ea, eb;
    logic [22:0] ma, mb;
    logic [287:0] va, vb, s, one, rem, half;
    logic [24:0] sig;
    int p, sh, e;
    sa = a[31]; ea = a[30:23]; ma = a[22:0];
    sb = b[31] ^ op; eb = b[30:23]; mb = b[22:0];
    if ((ea == 8'hFF && ma != 0) || (eb == 8'hFF && mb != 0) ||
        (ea == 8'hFF && eb == 8'hFF && sa != sb)) return {QNAN, 3'b100};
    if (ea == 8'hFF) return {sa, 8'hFF, 23'd0, 3'b000};
    if (eb == 8'hFF) return {sb, 8'hFF, 23'd0, 3'b000};
    if (ea == 0 && eb == 0) return {sa & sb, 31'd0, 3'b000};
    va = (ea == 0) ? '0 : ({264'd0, 1'b1, ma} << (ea - 8'd1));
    vb = (eb == 0) ? '0 : ({264'd0, 1'b1, mb} << (eb - 8'd1));
    if (sa == sb) begin s = va + vb; ss = sa; end
    else if (va >= vb) begin s = va - vb; ss = sa; end
    else begin s = vb - va; ss = sb; end
    if (s == 0) return 35'd0;
    p = 0;
    for (int i = 0; i < 288; i++) if (s[i]) p = i;
    if (p <= 22) return {ss, 31'd0, 3'b000};
    sh   = p - 23;
    one  = 288'd1;
    sig  = 25'(s >> sh);
    rem  = s & ((one << sh) - one);
    half = (sh > 0) ? (one << (sh - 1)) : '0;
    inexact = (rem != 0);
    up  = (sh > 0) && ((rem > half) || (rem == half && sig[0]));
    sig = sig + {24'd0, up};
    e   = p - 22;
    if (sig[24]) begin sig = sig >> 1; e++; end
    if (e >= 255) return {ss, 8'hFF, 23'd0, 2'b01, inexact};
    return {ss, 8'(e), sig[22:0], 2'b00, inexact};
  endfunction

  // Drives one cycle at the negedge and scores both transfers due at the next posedge.
  task automatic step(input logic iv, input logic [31:0] a, input logic [31:0] b,
                      input logic op, input logic ordy, input logic [34:0] expv,
                      output bit acc);
    logic [34:0] e;
    logic [34:0] now;
    int ac;
    @(negedge clk);
    bus.in_valid = iv; bus.a = a; bus.b = b; bus.operation_select = op; bus.out_ready = ordy;
    #1;
    cyc++;
    acc = iv && bus.in_ready;
    if (acc) begin exp_q.push_back(expv); acc_q.push_back(cyc); end
    now = {bus.result, bus.flag_invalid, bus.flag_overflow, bus.flag_inexact};
    if (was_stalled) check("hold_stable", 64'(now), 64'(held));
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) check("unexpected_out_valid", 64'(bus.out_valid), 64'd0);
      else begin
        e  = exp_q.pop_front();
        ac = acc_q.pop_front();
        out_cnt++;
        check("result", 64'(bus.result), 64'(e[34:3]));
        check("flags_inv_ovf_inx", 64'({bus.flag_invalid, bus.flag_overflow, bus.flag_inexact}),
              64'(e[2:0]));
        check("fields", 64'({bus.sign_result, bus.exp_result, bus.mantissa_result}),
              64'(e[34:3]));
        if (lat_chk) check("latency", 64'(cyc - ac), 64'd3);
      end
    end
    if (bus.out_valid && !bus.out_ready) check("in_ready_stall", 64'(bus.in_ready), 64'd0);
    was_stalled = bus.out_valid && !bus.out_ready;
    held = now;
  endtask

  function automatic int pick_exp();
    case ($urandom_range(0, 2))
      0: return 0;
      1: return 255;
      default: return int'($urandom_range(1, 254));
    endcase
  endfunction

  task automatic gen(output logic [31:0] a, output logic [31:0] b, output logic op);
    logic [31:0] ra, rb;
    int m, ea, eb;
    ra = $urandom; rb = $urandom;
    m  = int'($urandom_range(0, 9));
    ea = int'($urandom_range(1, 254));
    eb = ea + int'($urandom_range(0, 60)) - 30;
    if (m == 2) begin ea = int'($urandom_range(248, 254)); eb = ea - int'($urandom_range(0, 3)); end
    if (eb < 1) eb = 1;
    if (eb > 254) eb = 254;
    if (m == 1) begin ea = pick_exp(); eb = pick_exp(); end
    a = {ra[31], 8'(ea), ra[22:0]};
    b = {rb[31], 8'(eb), rb[22:0]};
    if (m == 0) begin a = ra; b = rb; end
    if (m == 3) b = a ^ {28'd0, rb[3:0]};
    op = 1'($urandom_range(0, 1));
  endtask

  logic [31:0] da[$], db[$];
  logic        dop[$];
  logic [34:0] dexp[$];

  task automatic add_dir(input logic [31:0] a, input logic [31:0] b, input logic op,
                         input logic [31:0] r, input logic [2:0] f);
    da.push_back(a); db.push_back(b); dop.push_back(op); dexp.push_back({r, f});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit acc;
    logic [31:0] a, b;
    logic op;
    int sent, base;

    bus.in_valid = 0; bus.a = 0; bus.b = 0; bus.operation_select = 0; bus.out_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_result", 64'(bus.result), 64'd0);
    check("rst_flags", 64'({bus.flag_invalid, bus.flag_overflow, bus.flag_inexact}), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);

    add_dir(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000);
    add_dir(32'h3FC00000, 32'h3F800000, 1'b0, 32'h40200000, 3'b000);
    add_dir(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000);
    add_dir(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001);
    add_dir(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b010);
    add_dir(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100);
    add_dir(32'h00000001, 32'h00000000, 1'b0, 32'h00000000, 3'b000);
    add_dir(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000);
    add_dir(32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 3'b000);
    add_dir(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100);
    add_dir(32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 3'b000);
    add_dir(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b001);
    add_dir(32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 3'b000);

    lat_chk = 1'b1;
    for (int i = 0; i < da.size(); i++) step(1'b1, da[i], db[i], dop[i], 1'b1, dexp[i], acc);
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) step(1'b0, '0, '0, 1'b0, 1'b1, '0, acc);
    check("dir_drained", 64'(exp_q.size()), 64'd0);
    lat_chk = 1'b0;

    base = out_cnt;
    sent = 0;
    for (int c = 0; c < 40 && sent < 8; c++) begin
      gen(a, b, op);
      step(1'b1, a, b, op, !(c >= 3 && c < 7), ref_model(a, b, op), acc);
      if (acc) sent++;
    end
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) step(1'b0, '0, '0, 1'b0, 1'b1, '0, acc);
    check("stream_sent", 64'(sent), 64'd8);
    check("stream_out_count", 64'(out_cnt - base), 64'd8);
    check("stream_drained", 64'(exp_q.size()), 64'd0);

    for (int i = 0; i < 3; i++) begin
      gen(a, b, op);
      step(1'b1, a, b, op, 1'b1, ref_model(a, b, op), acc);
    end
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    exp_q.delete();
    acc_q.delete();
    was_stalled = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(1'b0, '0, '0, 1'b0, 1'b1, '0, acc);
      check("midrst_quiet", 64'(bus.out_valid), 64'd0);
    end

    for (int c = 0; c < 500; c++) begin
      gen(a, b, op);
      step($urandom_range(0, 3) != 0, a, b, op, $urandom_range(0, 4) != 0,
           ref_model(a, b, op), acc);
    end
    for (int k = 0; k < 50 && exp_q.size() > 0; k++) step(1'b0, '0, '0, 1'b0, 1'b1, '0, acc);
    check("rand_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
